// File: rtl/module_regfile_wr_arbiter.sv
// Write-port arbiter for module_regfile: N_REQ writers share we3/a3/wd3, plus a clear sequencer zeroing regs 1..31.
// Grant is combinational; the granted write appears on the registered port one cycle later.
// stall_i blocks grants and clear writes; ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module module_regfile_wr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [5*N_REQ-1:0]    a_i,
  input  logic [32*N_REQ-1:0]   wd_i,
  input  logic                  stall_i,
  input  logic                  clr_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic                  busy_o,
  output logic                  we3_o,
  output logic [4:0]            a3_o,
  output logic [31:0]           wd3_o
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic [4:0]       sel_a;
  logic [31:0]      sel_wd;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last;
`endif

  assign busy_o = (state == CLEAR);

  // Winner search; rst_i, CLEAR, stall_i and clr_i all suppress granting.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    if (!rst_i && state == ARB && !stall_i && !clr_i) begin
      for (int i = 0; i < N_REQ; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
        cand = IDX_W'((int'(last) + 1 + i) % N_REQ);
`else
        cand = IDX_W'(i);
`endif
        if (!found && req_i[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_o  = '0;
    sel_a  = '0;
    sel_wd = '0;
    if (found) gnt_o[win] = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        sel_a  = a_i[5*k +: 5];
        sel_wd = wd_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB;
      cnt   <= 5'd1;
      we3_o <= 1'b0;
      a3_o  <= '0;
      wd3_o <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last  <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      we3_o <= 1'b0;
      case (state)
        ARB: begin
          if (clr_i) begin
            state <= CLEAR;
            cnt   <= 5'd1;
          end else if (found) begin
`ifdef ARB_ROUND_ROBIN_EN
            last <= win;
`endif
            // Writes to r0 are consumed but never reach the port.
            if (sel_a != 5'd0) begin
              we3_o <= 1'b1;
              a3_o  <= sel_a;
              wd3_o <= sel_wd;
            end
          end
        end
        CLEAR: begin
          if (!stall_i) begin
            we3_o <= 1'b1;
            a3_o  <= cnt;
            wd3_o <= '0;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_module_regfile_wr_arbiter.sv
// Directed plus randomized bench for module_regfile_wr_arbiter against a behavioural write-port model.
module tb_module_regfile_wr_arbiter;
  localparam int N_REQ = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N_REQ-1:0]    req_i;
  logic [5*N_REQ-1:0]  a_i;
  logic [32*N_REQ-1:0] wd_i;
  logic                stall_i;
  logic                clr_i;
  logic [N_REQ-1:0]    gnt_o;
  logic                busy_o;
  logic                we3_o;
  logic [4:0]          a3_o;
  logic [31:0]         wd3_o;

  module_regfile_wr_arbiter #(.N_REQ(N_REQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .wd_i(wd_i),
    .stall_i(stall_i), .clr_i(clr_i), .gnt_o(gnt_o), .busy_o(busy_o),
    .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: expected port contents, clear progress and round-robin pointer.
  bit          m_clear = 1'b0;
  int          m_cnt   = 1;
  int          m_last  = N_REQ - 1;
  bit          m_we    = 1'b0;
  logic [4:0]  m_a     = '0;
  logic [31:0] m_wd    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] r, input int last);
    int idx;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (last + 1 + i) % N_REQ;
`else
      idx = i;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check combinational grant mid-cycle, then registered outputs just after the edge.
  task automatic cycle();
    int                w;
    logic [N_REQ-1:0]  eg;
    logic [4:0]        wa;
    bit                nclear, nwe;
    int                ncnt, nlast;
    logic [4:0]        na;
    logic [31:0]       nwd;
    @(negedge clk_i);
    w  = (rst_i || m_clear || stall_i || clr_i) ? -1 : pick(req_i, m_last);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 32'(gnt_o), 32'(eg));
    nclear = m_clear; ncnt = m_cnt; nlast = m_last;
    nwe = 1'b0; na = m_a; nwd = m_wd;
    if (rst_i) begin
      nclear = 1'b0; na = '0; nwd = '0; nlast = N_REQ - 1;
    end else if (m_clear) begin
      if (!stall_i) begin
        nwe = 1'b1; na = 5'(m_cnt); nwd = '0; ncnt = m_cnt + 1;
        if (m_cnt == 31) nclear = 1'b0;
      end
    end else if (clr_i) begin
      nclear = 1'b1; ncnt = 1;
    end else if (w >= 0) begin
      nlast = w;
      wa = a_i[5*w +: 5];
      if (wa != 5'd0) begin
        nwe = 1'b1; na = wa; nwd = wd_i[32*w +: 32];
      end
    end
    @(posedge clk_i);
    #1;
    m_clear = nclear; m_cnt = ncnt; m_last = nlast;
    m_we = nwe; m_a = na; m_wd = nwd;
    chk("we3", 32'(we3_o), 32'(m_we));
    chk("a3", 32'(a3_o), 32'(m_a));
    chk("wd3", wd3_o, m_wd);
    chk("busy", 32'(busy_o), 32'(m_clear));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  // Runs a clear sequence; optional stall at cnt=10 for 3 cycles, optional reset once 15 cycles are busy.
  task automatic run_clear(input bit stall_mode, input bit rst_mode,
                           output int bcount, output logic [31:0] seen, output bit dup);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    bcount = 0; seen = '0; dup = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (!busy_o) break;
      bcount++;
      stall_i = stall_mode && bcount >= 10 && bcount <= 12;
      rst_i   = rst_mode && bcount == 15;
      cycle();
      if (we3_o) begin
        if (seen[a3_o]) dup = 1'b1;
        seen[a3_o] = 1'b1;
      end
    end
    stall_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  int          bc;
  logic [31:0] seen;
  bit          dup;

  initial begin
    req_i = '0; a_i = '0; wd_i = '0; stall_i = 1'b0; clr_i = 1'b0;
    do_reset();
    chk("reset_we3", 32'(we3_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);

    // Single write from requester 0.
    req_i = 2'b01; a_i = {5'd0, 5'd5}; wd_i = {32'h0, 32'hDEADBEEF};
    cycle();
    req_i = '0;
    chk("single_a3", 32'(a3_o), 32'd5);
    chk("single_wd3", wd3_o, 32'hDEADBEEF);
    cycle();
    chk("single_we3_drop", 32'(we3_o), 32'd0);

    // Both requesting for four cycles from a fresh pointer.
    do_reset();
    req_i = 2'b11; a_i = {5'd7, 5'd3}; wd_i = {32'hB, 32'hA};
    repeat (4) cycle();
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr_last_a3", 32'(a3_o), 32'd7);
`else
    chk("fp_last_a3", 32'(a3_o), 32'd3);
`endif
    req_i = '0;
    cycle();

    // Write to r0 is granted but dropped.
    req_i = 2'b01; a_i = {5'd0, 5'd0}; wd_i = {32'h0, 32'h1234};
    cycle();
    req_i = '0;
    chk("r0_we3", 32'(we3_o), 32'd0);

    // Clear with a simultaneous request, no stalls.
    req_i = 2'b01; a_i = {5'd0, 5'd9}; wd_i = {32'h0, 32'h55};
    run_clear(1'b0, 1'b0, bc, seen, dup);
    chk("clr_busy_len", 32'(bc), 32'd31);
    chk("clr_addr_set", seen, 32'hFFFF_FFFE);
    chk("clr_no_dup", 32'(dup), 32'd0);
    cycle();
    chk("clr_then_req_a3", 32'(a3_o), 32'd9);
    req_i = '0;
    cycle();

    // Clear with a 3-cycle stall at cnt=10.
    run_clear(1'b1, 1'b0, bc, seen, dup);
    chk("stall_busy_len", 32'(bc), 32'd34);
    chk("stall_addr_set", seen, 32'hFFFF_FFFE);
    chk("stall_no_dup", 32'(dup), 32'd0);
    cycle();

    // Reset mid-clear, then pointer restart.
    run_clear(1'b0, 1'b1, bc, seen, dup);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_we3", 32'(we3_o), 32'd0);
    req_i = 2'b10; a_i = {5'd4, 5'd6}; wd_i = {32'h44, 32'h66};
    cycle();
    req_i = 2'b11;
    cycle();
    req_i = '0;
    chk("post_rst_req0_wins", 32'(a3_o), 32'd6);
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req_i   = N_REQ'($urandom);
      stall_i = ($urandom_range(0, 5) == 0);
      clr_i   = ($urandom_range(0, 60) == 0);
      rst_i   = ($urandom_range(0, 150) == 0);
      for (int k = 0; k < N_REQ; k++) begin
        a_i[5*k +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        wd_i[32*k +: 32] = $urandom;
      end
      cycle();
    end
    req_i = '0; stall_i = 1'b0; clr_i = 1'b0; rst_i = 1'b0;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_regfile_wr_arbiter.md
Name: module_regfile_wr_arbiter

Overview:
Shares the register file's single write port (we3/a3/wd3) between N_REQ writers, such as multi-cycle datapath writeback and a debug/loader path.
- Per-requester valid/grant handshake.
- Round-robin arbitration, or fixed priority when the macro is off.
- Registered drive of the regfile write port.
- Built-in clear sequencer that zeroes registers 1..31 without using the regfile's reset.
- Sits between the writers and module_regfile.

Parameters:
N_REQ, 2, number of write requesters; legal range 2..8.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  reset, synchronous, active-high.
req_i  in  N_REQ  per-requester write request; held until granted.
a_i  in  5*N_REQ  target register index; requester k uses bits [5k+4:5k].
wd_i  in  32*N_REQ  write data; requester k uses bits [32k+31:32k].
stall_i  in  1  write port unavailable this cycle; no grant, no write issued.
clr_i  in  1  single-cycle pulse; starts the clear sequence.
gnt_o  out  N_REQ  one-hot grant; combinational; at most one bit set.
busy_o  out  1  high while clear sequence is active.
we3_o  out  1  registered write enable to regfile.
a3_o  out  5  registered write address to regfile.
wd3_o  out  32  registered write data to regfile.

Behaviour:
- Reset (rst_i=1 at rising edge) forces the following; a reset mid-clear aborts the sequence immediately.
  - state=ARB.
  - we3_o=0, a3_o=0, wd3_o=0, busy_o=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 is first.
  - gnt_o=0 while rst_i=1.
- States:
  - ARB: normal arbitration.
  - CLEAR: sequential zeroing.
- Grant in ARB is computed combinationally.
  - When stall_i=0, clr_i=0 and req_i!=0, exactly one gnt_o bit is set.
  - Search starts at (last+1) mod N_REQ and wraps.
  - On grant, last is set to the winner index at the clock edge.
- Handshake: a request is consumed in the cycle gnt_o[k]=1.
  - The requester may change a_i/wd_i or drop req_i on the following cycle.
  - Deasserting req_i before grant withdraws the request with no side effects.
- Write latency: grant at cycle t gives we3_o=1, a3_o=a_i[k], wd3_o=wd_i[k] during cycle t+1.
  - Outputs are registered.
  - we3_o is high for exactly one cycle per grant.
- Address 0: the request is granted normally (gnt_o pulses, last updates), but we3_o stays 0. The write is dropped and a3_o/wd3_o keep their previous values.
- No grant in a cycle means we3_o=0 next cycle; a3_o/wd3_o hold their previous values.
- stall_i=1 in ARB: gnt_o=0, last unchanged, we3_o=0 next cycle.
- clr_i=1 in ARB:
  - Takes priority over requests and stall_i; gnt_o=0 that cycle.
  - Next state is CLEAR with counter cnt=1.
- CLEAR, each cycle with stall_i=0:
  - Registered outputs for the next cycle are we3_o=1, a3_o=cnt, wd3_o=0.
  - cnt increments.
  - After issuing cnt=31, the FSM returns to ARB.
  - The 31 writes cover addresses 1..31 in ascending order.
  - With no stalls, busy_o is high for exactly 31 cycles, starting the cycle after the clr_i pulse.
- CLEAR with stall_i=1: cnt holds and we3_o=0 next cycle.
- In CLEAR: gnt_o=0 always; clr_i is ignored; last is unchanged.
- busy_o is registered: it equals 1 exactly when state=CLEAR.
- The write to address 31 appears on we3_o in the first ARB cycle after CLEAR. A grant in that same cycle produces its write on the following cycle, so the two never collide.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration using the last pointer, as specified above.
- Undefined: fixed priority, lowest index wins.
  - The last register is not implemented.
  - All other behaviour (handshake, latency, address 0 drop, stall, CLEAR) is identical.

Test Plan:
- Reset, then req_i=01, a_i[0]=5, wd_i[0]=0xDEADBEEF -> gnt_o=01 that cycle; next cycle we3_o=1, a3_o=5, wd3_o=0xDEADBEEF; following cycle we3_o=0.
- req_i=11 held 4 cycles, a_i={7,3}, wd_i={0xB,0xA} -> with macro: grants 01,10,01,10 and writes (3,0xA),(7,0xB),(3,0xA),(7,0xB); without macro: grants 01 all four cycles.
- req_i=01, a_i[0]=0, wd_i[0]=0x1234 -> gnt_o=01, we3_o stays 0; a subsequent read of register 0 via the regfile returns 0.
- Pulse clr_i with req_i=01 in the same cycle -> gnt_o=0; busy_o high 31 cycles; we3_o=1 with a3_o 1..31 ascending and wd3_o=0; then req0 granted; all regfile registers read 0.
- During CLEAR, stall_i=1 for 3 cycles at cnt=10 -> no writes for 3 cycles, then resumes at a3_o=10; busy_o lasts 34 cycles total; no address skipped or repeated.
- rst_i=1 at cnt=15 in CLEAR -> next cycle busy_o=0 and we3_o=0; after release, req_i=10 -> gnt_o=10 (with macro: pointer restarted so req0 would win if also requesting).
